serial_subtractor_8bit: RTL and testbench
=========================================

// Module: serial_subtractor_8bit
// PURPOSE
//  Bit-serial subtractor: computes D = X - Y one bit per clock, LSB first,
//  using a single full-subtractor stage and a borrow flip-flop.
//  Companion to the parallel ripple-carry adder; trades WIDTH cycles of
//  latency for one arithmetic cell. Start/Busy/Done handshake to control FSM.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  Clock  in   1      system clock, rising edge
//  Reset  in   1      synchronous, active-high reset
//  Start  in   1      request; sampled only in IDLE
//  X      in   WIDTH  minuend, captured on the accepted Start edge
//  Y      in   WIDTH  subtrahend, captured on the accepted Start edge
//  D      out  WIDTH  difference X - Y (mod 2^WIDTH), registered
//  Bo     out  1      final borrow out: 1 iff X < Y (unsigned)
//  Busy   out  1      high while bits are being processed
//  Done   out  1      one-cycle pulse: D/Bo valid
//  Ovf    out  1      signed overflow (only with SERSUB_OVF_EN)
// BEHAVIOUR
//  - One clock, synchronous active-high reset, single clock domain.
//  - Reset: state=IDLE; D=0, Bo=0, Busy=0, Done=0, Ovf=0; shift regs,
//    borrow FF and bit counter cleared. Reset mid-operation aborts the
//    subtraction; no Done is produced.
//  - FSM states IDLE, SHIFT, DONE:
//    IDLE : Start=1 -> load X,Y into shift regs, borrow=0, count=0 -> SHIFT.
//           Start=0 -> stay.
//    SHIFT: Busy=1. Each edge: a=xs[0], b=ys[0];
//           d = a^b^bin; bout = (~a&b) | (~(a^b)&bin);
//           result reg shifts right, d inserted at MSB; xs,ys shift right;
//           borrow<=bout; count++. After the WIDTH-th bit -> DONE.
//    DONE : Done=1 for this cycle only; -> IDLE unconditionally.
//  - D and Bo updated only on the SHIFT->DONE transition (copy of result
//    reg and final borrow); held stable otherwise, including during the
//    next operation, until the next transition to DONE.
//  - Latency: Done is high in the cycle following the (WIDTH+1)th rising
//    edge counted from the edge that sampled Start (edge 0 = accept).
//  - Start while Busy or Done is ignored (not queued); X/Y changes after
//    acceptance have no effect.
//  - Back-to-back: Start held high re-accepts in IDLE the cycle after
//    DONE; throughput one result per WIDTH+2 cycles.
//  - Arithmetic is modulo 2^WIDTH; no saturation.
// CONFIGURATION
//  SERSUB_OVF_EN defined: Ovf port present; on SHIFT->DONE,
//   Ovf <= (X[W-1] != Y[W-1]) && (D[W-1] != X[W-1]) using captured MSBs;
//   reset value 0, held like D.
//  SERSUB_OVF_EN undefined: Ovf port and its logic absent; all other
//   behaviour identical.
// TESTING
//  - X=100, Y=58, Start 1 cycle -> Done pulse after WIDTH+1 edges, D=42, Bo=0.
//  - X=5, Y=10 -> D=251 (8'hFB), Bo=1; Busy high exactly 8 cycles.
//  - X=0,Y=0 and X=255,Y=255 -> D=0, Bo=0; X=0,Y=1 -> D=8'hFF, Bo=1.
//  - Pulse Start with new X/Y during Busy -> ignored; result of first op only.
//  - Reset asserted at bit 4 of an op -> next cycle IDLE, Busy=0, D=0,
//    no Done; new Start then completes correctly.
//  - SERSUB_OVF_EN: X=8'h80,Y=8'h01 -> D=8'h7F, Ovf=1; X=8'h10,Y=8'h01 ->
//    D=8'h0F, Ovf=0.

Source files
------------

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor: D = X - Y, one bit per clock LSB first, through a single
// full-subtractor cell and a borrow flop. Optional signed-overflow flag: SERSUB_OVF_EN.
`timescale 1ns/1ps

module serial_subtractor_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             Busy,
    output logic             Done
`ifdef SERSUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CNT_W-1:0] count;

    logic load_c;
    logic shift_c;
    logic last_c;
    logic bit_a_c;
    logic bit_b_c;
    logic diff_c;
    logic bout_c;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Start is only looked at in IDLE
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (Start) state_next = S_SHIFT;
            S_SHIFT: if (count == LAST_BIT) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        load_c  = 1'b0;
        shift_c = 1'b0;
        last_c  = 1'b0;
        case (state)
            S_IDLE:  load_c  = Start;
            S_SHIFT: begin
                shift_c = 1'b1;
                last_c  = (count == LAST_BIT);
            end
            default: ;
        endcase
    end

    // Single full-subtractor cell
    always_comb begin
        bit_a_c = xs[0];
        bit_b_c = ys[0];
        diff_c  = bit_a_c ^ bit_b_c ^ borrow;
        bout_c  = (~bit_a_c & bit_b_c) | (~(bit_a_c ^ bit_b_c) & borrow);
    end

    // Operand shift registers, partial result, borrow and bit counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            xs     <= '0;
            ys     <= '0;
            res    <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else if (load_c) begin
            xs     <= X;
            ys     <= Y;
            res    <= '0;
            borrow <= 1'b0;
            count  <= '0;
        end else if (shift_c) begin
            xs     <= {1'b0, xs[WIDTH-1:1]};
            ys     <= {1'b0, ys[WIDTH-1:1]};
            res    <= {diff_c, res[WIDTH-1:1]};
            borrow <= bout_c;
            count  <= count + CNT_W'(1);
        end
    end

    // Result outputs change only when the last bit completes
    always_ff @(posedge Clock) begin
        if (Reset) begin
            D  <= '0;
            Bo <= 1'b0;
        end else if (last_c) begin
            D  <= {diff_c, res[WIDTH-1:1]};
            Bo <= bout_c;
        end
    end

`ifdef SERSUB_OVF_EN
    // On the last bit the cell inputs are the operand sign bits
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Ovf <= 1'b0;
        end else if (last_c) begin
            Ovf <= (bit_a_c != bit_b_c) && (diff_c != bit_a_c);
        end
    end
`endif

    // Handshake flags registered from the next state so they align with it
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Busy <= (state_next == S_SHIFT);
            Done <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// Directed bench for serial_subtractor_8bit; covers the Ovf flag when SERSUB_OVF_EN is defined.
`timescale 1ns/1ps

module tb_serial_subtractor_8bit;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [7:0] X;
    logic [7:0] Y;
    logic [7:0] D;
    logic       Bo;
    logic       Busy;
    logic       Done;
`ifdef SERSUB_OVF_EN
    logic       Ovf;
`endif

    int total;
    int bad;

    serial_subtractor_8bit #(.WIDTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Start (Start),
        .X     (X),
        .Y     (Y),
        .D     (D),
        .Bo    (Bo),
        .Busy  (Busy),
        .Done  (Done)
`ifdef SERSUB_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One Start pulse; reports edges to Done, Busy-high cycles and D one cycle after accept
    task automatic do_op(input logic [7:0] xv, input logic [7:0] yv,
                         output int lat, output int busy_n, output logic [7:0] d_mid);
        X = xv;
        Y = yv;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        d_mid = D;
        lat = 0;
        busy_n = (Busy === 1'b1) ? 1 : 0;
        while (Done !== 1'b1 && lat < 30) begin
            tick;
            lat++;
            if (Busy === 1'b1) busy_n++;
        end
    endtask

    initial begin
        int lat;
        int busy_n;
        int n;
        logic [7:0] d_mid;
        logic seen_done;

        total = 0;
        bad = 0;
        Reset = 1'b1;
        Start = 1'b0;
        X = 8'd0;
        Y = 8'd0;
        tick;
        tick;
        Reset = 1'b0;
        chk("rst_d", 32'(D), 32'h00);
        chk("rst_bo", 32'(Bo), 32'h0);
        chk("rst_busy", 32'(Busy), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
`ifdef SERSUB_OVF_EN
        chk("rst_ovf", 32'(Ovf), 32'h0);
`endif
        tick;

        // 100 - 58
        do_op(8'd100, 8'd58, lat, busy_n, d_mid);
        chk("op1_done", 32'(Done), 32'h1);
        chk("op1_lat", 32'(lat), 32'd8);
        chk("op1_busy", 32'(busy_n), 32'd8);
        chk("op1_d", 32'(D), 32'd42);
        chk("op1_bo", 32'(Bo), 32'h0);
        tick;
        chk("op1_pulse", 32'(Done), 32'h0);
        chk("op1_hold", 32'(D), 32'd42);

        // 5 - 10, previous result held during the operation
        do_op(8'd5, 8'd10, lat, busy_n, d_mid);
        chk("op2_dmid", 32'(d_mid), 32'd42);
        chk("op2_done", 32'(Done), 32'h1);
        chk("op2_busy", 32'(busy_n), 32'd8);
        chk("op2_d", 32'(D), 32'hFB);
        chk("op2_bo", 32'(Bo), 32'h1);
        tick;

        do_op(8'd0, 8'd0, lat, busy_n, d_mid);
        chk("zero_d", 32'(D), 32'h00);
        chk("zero_bo", 32'(Bo), 32'h0);
        tick;
        do_op(8'd255, 8'd255, lat, busy_n, d_mid);
        chk("ff_d", 32'(D), 32'h00);
        chk("ff_bo", 32'(Bo), 32'h0);
        tick;
        do_op(8'd0, 8'd1, lat, busy_n, d_mid);
        chk("m1_d", 32'(D), 32'hFF);
        chk("m1_bo", 32'(Bo), 32'h1);
        tick;

        // Start pulsed with new operands during Busy must be ignored
        X = 8'd7;
        Y = 8'd3;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        tick;
        X = 8'd200;
        Y = 8'd1;
        Start = 1'b1;
        tick;
        tick;
        Start = 1'b0;
        n = 0;
        while (Done !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        chk("ign_done", 32'(Done), 32'h1);
        chk("ign_d", 32'(D), 32'd4);
        chk("ign_bo", 32'(Bo), 32'h0);
        // Start seen only during the Done cycle is also dropped
        Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        chk("ign_dn_busy", 32'(Busy), 32'h0);
        tick;

        // Back-to-back with Start held; operands changed after first accept
        X = 8'd20;
        Y = 8'd30;
        Start = 1'b1;
        tick;
        X = 8'd50;
        Y = 8'd8;
        n = 0;
        while (Done !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        chk("b2b1_done", 32'(Done), 32'h1);
        chk("b2b1_d", 32'(D), 32'd246);
        chk("b2b1_bo", 32'(Bo), 32'h1);
        n = 0;
        tick;
        n++;
        while (Done !== 1'b1 && n < 30) begin
            tick;
            n++;
        end
        chk("b2b_period", 32'(n), 32'd10);
        chk("b2b2_d", 32'(D), 32'd42);
        chk("b2b2_bo", 32'(Bo), 32'h0);
        Start = 1'b0;
        tick;
        tick;
        chk("b2b_idle", 32'(Busy), 32'h0);

        // Reset during bit processing aborts the operation
        X = 8'd200;
        Y = 8'd100;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        tick;
        tick;
        tick;
        tick;
        Reset = 1'b1;
        tick;
        Reset = 1'b0;
        chk("abort_busy", 32'(Busy), 32'h0);
        chk("abort_done", 32'(Done), 32'h0);
        chk("abort_d", 32'(D), 32'h00);
        chk("abort_bo", 32'(Bo), 32'h0);
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (Done === 1'b1) seen_done = 1'b1;
        end
        chk("abort_nodone", 32'(seen_done), 32'h0);
        do_op(8'd0, 8'd1, lat, busy_n, d_mid);
        chk("post_lat", 32'(lat), 32'd8);
        chk("post_d", 32'(D), 32'hFF);
        chk("post_bo", 32'(Bo), 32'h1);
        tick;

`ifdef SERSUB_OVF_EN
        do_op(8'h80, 8'h01, lat, busy_n, d_mid);
        chk("ovf1_d", 32'(D), 32'h7F);
        chk("ovf1_ovf", 32'(Ovf), 32'h1);
        tick;
        do_op(8'h10, 8'h01, lat, busy_n, d_mid);
        chk("ovf0_d", 32'(D), 32'h0F);
        chk("ovf0_ovf", 32'(Ovf), 32'h0);
        tick;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
